mem_access: RTL and testbench

Memory-access (MEM) stage of the 16-bit 5-stage pipeline, directly upstream of the write-back unit. It accepts one instruction per cycle from the EX stage and performs data-memory loads and stores against an internal synchronous RAM. It registers the MEM/WB pipeline fields that the write-back unit consumes: instruction, ALU output, memory data and destination register number. Loads stall the upstream stage for one cycle.

---
 rtl/mem_access_pkg.sv | 18 +
 rtl/mem_access_data_mem.sv | 29 ++
 rtl/mem_access.sv | 105 ++++++++++
 tb/tb_mem_access.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared pipeline constants for the MEM and WB stages: widths, opcodes, MEM-stage FSM states.
package mem_access_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int REG_W  = 4;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_LOAD  = 4'b0011;
  localparam logic [OP_W-1:0] OP_STORE = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOP   = 4'b1111;

  typedef enum logic {
    ST_RUN,
    ST_LOAD_WAIT
  } mem_state_e;

endpackage

// File: rtl/mem_access_data_mem.sv
// Single-port synchronous data RAM: write on the edge, read data registered on the edge.
module data_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately unreset so this maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: one instruction per cycle, loads stall EX for one cycle while RAM data returns.
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   instruction_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  reg_nos_in,
  output logic              out_valid,
  output logic [OP_W-1:0]   instruction_out,
  output logic [DATA_W-1:0] alu_output_out,
  output logic [DATA_W-1:0] data_from_mem_out,
  output logic [REG_W-1:0]  reg_nos_out
);

  mem_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_W-1:0]  reg_q, reg_d;

  logic              accept;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;
  assign mem_we   = accept && (instruction_in == OP_STORE);
  assign mem_re   = accept && (instruction_in == OP_LOAD);

  data_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (alu_result_in[ADDR_W-1:0]),
    .wdata_i (store_data_in),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    instr_d     = OP_NOP;
    alu_d       = alu_q;
    data_d      = data_q;
    reg_d       = reg_q;
    case (state_q)
      ST_RUN: begin
        if (accept && (instruction_in != OP_NOP)) begin
          alu_d  = alu_result_in;
          reg_d  = reg_nos_in;
          data_d = '0;
          if (instruction_in == OP_LOAD) begin
            state_d = ST_LOAD_WAIT;
          end else begin
            out_valid_d = 1'b1;
            instr_d     = instruction_in;
          end
        end
      end
      ST_LOAD_WAIT: begin
        // Registered RAM output is valid now; hand it to WB with the load's fields.
        out_valid_d = 1'b1;
        instr_d     = OP_LOAD;
        data_d      = mem_rdata;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      instr_q     <= OP_NOP;
      alu_q       <= '0;
      data_q      <= '0;
      reg_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      alu_q       <= alu_d;
      data_q      <= data_d;
      reg_q       <= reg_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign instruction_out   = instr_q;
  assign alu_output_out    = alu_q;
  assign data_from_mem_out = data_q;
  assign reg_nos_out       = reg_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomised bench for mem_access against a transaction-level model of the MEM stage.
module tb_mem_access;
  import mem_access_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   instruction_in = OP_NOP;
  logic [DATA_W-1:0] alu_result_in = '0;
  logic [DATA_W-1:0] store_data_in = '0;
  logic [REG_W-1:0]  reg_nos_in = '0;
  logic              out_valid;
  logic [OP_W-1:0]   instruction_out;
  logic [DATA_W-1:0] alu_output_out;
  logic [DATA_W-1:0] data_from_mem_out;
  logic [REG_W-1:0]  reg_nos_out;

  mem_access dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .instruction_in    (instruction_in),
    .alu_result_in     (alu_result_in),
    .store_data_in     (store_data_in),
    .reg_nos_in        (reg_nos_in),
    .out_valid         (out_valid),
    .instruction_out   (instruction_out),
    .alu_output_out    (alu_output_out),
    .data_from_mem_out (data_from_mem_out),
    .reg_nos_out       (reg_nos_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: memory image, one outstanding load, expected visible outputs.
  logic [DATA_W-1:0] mem_m [256];
  bit                wait_load = 1'b0;
  logic [7:0]        pend_addr;
  logic [DATA_W-1:0] pend_alu;
  logic [REG_W-1:0]  pend_reg;
  bit                last_acc = 1'b0;
  bit                chk_en = 1'b0;
  logic              exp_ready = 1'b1;
  logic              exp_valid = 1'b0;
  logic [OP_W-1:0]   exp_op = OP_NOP;
  logic [DATA_W-1:0] exp_alu = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [REG_W-1:0]  exp_reg = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("instruction_out", 32'(instruction_out), 32'(exp_op));
      if (exp_valid) begin
        chk("alu_output_out", 32'(alu_output_out), 32'(exp_alu));
        chk("data_from_mem_out", 32'(data_from_mem_out), 32'(exp_data));
        chk("reg_nos_out", 32'(reg_nos_out), 32'(exp_reg));
      end
    end
  end

  task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] sd, input logic [REG_W-1:0] rn);
    in_valid       = v;
    instruction_in = op;
    alu_result_in  = alu;
    store_data_in  = sd;
    reg_nos_in     = rn;
  endtask

  // What one clock edge does to the stage, from the inputs held across it.
  task automatic model_update();
    logic acc;
    acc      = in_valid && exp_ready;
    last_acc = acc;
    if (wait_load) begin
      exp_valid = 1'b1;
      exp_op    = OP_LOAD;
      exp_alu   = pend_alu;
      exp_reg   = pend_reg;
      exp_data  = mem_m[pend_addr];
      wait_load = 1'b0;
    end else if (acc && instruction_in != OP_NOP) begin
      exp_alu  = alu_result_in;
      exp_reg  = reg_nos_in;
      exp_data = '0;
      if (instruction_in == OP_LOAD) begin
        wait_load = 1'b1;
        pend_addr = alu_result_in[7:0];
        pend_alu  = alu_result_in;
        pend_reg  = reg_nos_in;
        exp_valid = 1'b0;
        exp_op    = OP_NOP;
      end else begin
        exp_valid = 1'b1;
        exp_op    = instruction_in;
        if (instruction_in == OP_STORE) mem_m[alu_result_in[7:0]] = store_data_in;
      end
    end else begin
      exp_valid = 1'b0;
      exp_op    = OP_NOP;
    end
    exp_ready = !wait_load;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic model_reset();
    wait_load = 1'b0;
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_op    = OP_NOP;
    exp_alu   = '0;
    exp_data  = '0;
    exp_reg   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " instruction_out"}, 32'(instruction_out), 32'(OP_NOP));
    chk({tag, " alu_output_out"}, 32'(alu_output_out), 32'd0);
    chk({tag, " data_from_mem_out"}, 32'(data_from_mem_out), 32'd0);
    chk({tag, " reg_nos_out"}, 32'(reg_nos_out), 32'd0);
  endtask

  task automatic rand_instr();
    logic [OP_W-1:0] op;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 3) op = OP_LOAD;
    else if (sel < 5) op = OP_STORE;
    else if (sel == 5) op = OP_NOP;
    else begin
      op = OP_W'($urandom_range(0, 15));
      while (op == OP_LOAD || op == OP_STORE || op == OP_NOP) op = OP_W'($urandom_range(0, 15));
    end
    drive($urandom_range(0, 4) != 0, op, DATA_W'($urandom), DATA_W'($urandom), REG_W'($urandom));
  endtask

  initial begin
    // Reset asserted mid-cycle: outputs must take reset values without a clock edge.
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    drive(1'b1, 4'b0000, 16'h000D, 16'h0000, 4'd1);
    tick();
    drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0);
    chk("alu valid", 32'(out_valid), 32'd1);
    chk("alu result", 32'(alu_output_out), 32'h000D);
    chk("alu memdata", 32'(data_from_mem_out), 32'h0000);
    chk("alu reg", 32'(reg_nos_out), 32'd1);
    tick();

    drive(1'b1, OP_STORE, 16'h0005, 16'h000F, 4'd0);
    tick();
    drive(1'b1, OP_LOAD, 16'h0005, 16'h0000, 4'd2);
    tick();
    drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0);
    chk("load stall in_ready", 32'(in_ready), 32'd0);
    chk("load bubble valid", 32'(out_valid), 32'd0);
    tick();
    chk("load valid", 32'(out_valid), 32'd1);
    chk("load data", 32'(data_from_mem_out), 32'h000F);
    chk("load reg", 32'(reg_nos_out), 32'd2);
    chk("load ready back", 32'(in_ready), 32'd1);

    drive(1'b1, OP_STORE, 16'h0005, 16'h1234, 4'd3);
    tick();
    drive(1'b1, OP_LOAD, 16'hFF05, 16'h0000, 4'd4);
    tick();
    drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0);
    tick();
    chk("alias load data", 32'(data_from_mem_out), 32'h1234);

    // ALU, LOAD, ALU with in_valid held: out_valid 1,0,1,1.
    drive(1'b1, 4'b0001, 16'h0011, 16'h0000, 4'd5);
    tick();
    chk("b2b valid0", 32'(out_valid), 32'd1);
    drive(1'b1, OP_LOAD, 16'h0005, 16'h0000, 4'd6);
    tick();
    chk("b2b valid1", 32'(out_valid), 32'd0);
    drive(1'b1, 4'b0010, 16'h0022, 16'h0000, 4'd7);
    tick();
    chk("b2b valid2", 32'(out_valid), 32'd1);
    chk("b2b load op", 32'(instruction_out), 32'(OP_LOAD));
    tick();
    chk("b2b valid3", 32'(out_valid), 32'd1);
    chk("b2b alu2 op", 32'(instruction_out), 32'h2);
    chk("b2b alu2 result", 32'(alu_output_out), 32'h0022);
    drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0);
    tick();

    // Reset while a load is outstanding.
    drive(1'b1, OP_LOAD, 16'h0005, 16'h0000, 4'd8);
    tick();
    drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0);
    #2 chk_en = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("reset in wait");
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    tick();
    chk("post-reset no pulse", 32'(out_valid), 32'd0);
    tick();
    chk("post-reset no pulse 2", 32'(out_valid), 32'd0);
    drive(1'b1, 4'b0000, 16'h0077, 16'h0000, 4'd9);
    tick();
    drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0);
    chk("post-reset alu valid", 32'(out_valid), 32'd1);
    chk("post-reset alu result", 32'(alu_output_out), 32'h0077);
    tick();

    // Fill every RAM word so random loads always have a known value.
    for (int a = 0; a < 256; a++) begin
      drive(1'b1, OP_STORE, {8'($urandom), 8'(a)}, DATA_W'($urandom), REG_W'($urandom));
      tick();
    end

    rand_instr();
    for (int i = 0; i < 3000; i++) begin
      tick();
      // EX holds an unaccepted instruction; otherwise it presents a new one.
      if (!(in_valid && !last_acc)) rand_instr();
    end
    drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 4'd0);
    repeat (3) tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
